// File: rtl/cpu_pkg.sv
// Shared CPU definitions: alu op codes, RV32M funct3 encodings and the mdu sequencer states.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_PASSB = 4'b1001,
    ALU_SRA   = 4'b1101
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    MDU_IDLE = 3'd0,
    MDU_PREP = 3'd1,
    MDU_RUN  = 3'd2,
    MDU_FIX  = 3'd3,
    MDU_DONE = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply and restoring divide
// on magnitudes, borrowing the shared alu for the per-step add/subtract.
module mdu_seq
  import cpu_pkg::*;
#(
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctr,
  input  logic [31:0] alu_res
);

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  function automatic logic signed_a_op(input mdu_op_e o);
    case (o)
      MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic signed_b_op(input mdu_op_e o);
    case (o)
      MDU_MULH, MDU_DIV, MDU_REM: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_a_q, sign_a_d, neg_q, neg_d, div0_q, div0_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d, result_q, result_d;

  logic        is_div, sa, sb, skip, carry, sub, rtop;
  logic [31:0] abs_a, abs_b, sum, shrem;
  logic [63:0] prod;

  // Next-state, datapath update and alu operand selection.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_ctr  = ALU_ADD;
    is_div   = (op_q >= MDU_DIV);
    sa       = signed_a_op(op_q) & acc_lo_q[31];
    sb       = signed_b_op(op_q) & opb_q[31];
    abs_a    = sa ? neg32(acc_lo_q) : acc_lo_q;
    abs_b    = sb ? neg32(opb_q) : opb_q;
    skip     = is_div ? (opb_q == 32'd0) : ((acc_lo_q == 32'd0) || (opb_q == 32'd0));
    carry    = 1'b0;
    sub      = 1'b0;
    sum      = acc_hi_q;
    rtop     = acc_hi_q[31];
    shrem    = {acc_hi_q[30:0], acc_lo_q[31]};
    prod     = neg_q ? neg64({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};

    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          state_d  = MDU_PREP;
          op_d     = mdu_op_e'(op);
          acc_lo_d = rs1;
          opb_d    = rs2;
        end else begin
          state_d = MDU_IDLE;
        end
      end
      MDU_PREP: begin
        sign_a_d = sa;
        neg_d    = sa ^ sb;
        div0_d   = is_div & (opb_q == 32'd0);
        acc_hi_d = 32'd0;
        acc_lo_d = abs_a;
        opb_d    = abs_b;
        cnt_d    = 5'd31;
        state_d  = MDU_RUN;
        // Skipped ops load the registers with what a full run would have left behind.
        if (FAST_ZERO && skip) begin
          state_d  = MDU_FIX;
          acc_hi_d = is_div ? abs_a : 32'd0;
          acc_lo_d = is_div ? 32'hFFFF_FFFF : 32'd0;
        end else begin
          state_d = MDU_RUN;
        end
      end
      MDU_RUN: begin
        if (is_div) begin
          alu_a    = shrem;
          alu_b    = opb_q;
          alu_ctr  = ALU_SUB;
          sub      = rtop | (shrem >= opb_q);
          acc_hi_d = sub ? alu_res : shrem;
          acc_lo_d = {acc_lo_q[30:0], sub};
        end else begin
          alu_a    = acc_hi_q;
          alu_b    = opb_q;
          alu_ctr  = ALU_ADD;
          sum      = acc_lo_q[0] ? alu_res : acc_hi_q;
          carry    = acc_lo_q[0] & (alu_res < acc_hi_q);
          acc_hi_d = {carry, sum[31:1]};
          acc_lo_d = {sum[0], acc_lo_q[31:1]};
        end
        if (cnt_q == 5'd0) begin
          state_d = MDU_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      MDU_FIX: begin
        state_d = MDU_DONE;
        case (op_q)
          MDU_MUL:                         result_d = prod[31:0];
          MDU_MULH, MDU_MULHSU, MDU_MULHU: result_d = prod[63:32];
          MDU_DIV, MDU_DIVU:               result_d = div0_q ? 32'hFFFF_FFFF :
                                                      (neg_q ? neg32(acc_lo_q) : acc_lo_q);
          MDU_REM, MDU_REMU:               result_d = sign_a_q ? neg32(acc_hi_q) : acc_hi_q;
          default:                         result_d = result_q;
        endcase
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase

    if (flush && (state_q != MDU_IDLE)) begin
      state_d  = MDU_IDLE;
      result_d = result_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      op_q     <= MDU_MUL;
      cnt_q    <= 5'd0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opb_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != MDU_IDLE);
  assign done   = (state_q == MDU_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed and random RV32M ops against a 64-bit arithmetic reference,
// on a FAST_ZERO=1 and a FAST_ZERO=0 instance driven in lockstep.
module tb_mdu_seq;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy_f, done_f, busy_s, done_s;
  logic [31:0] result_f, alu_a_f, alu_b_f, alu_res_f;
  logic [31:0] result_s, alu_a_s, alu_b_s, alu_res_s;
  logic [3:0]  alu_ctr_f, alu_ctr_s;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = 32'd0;

  always #5 clk = ~clk;

  assign alu_res_f = (alu_ctr_f == ALU_SUB) ? (alu_a_f - alu_b_f) : (alu_a_f + alu_b_f);
  assign alu_res_s = (alu_ctr_s == ALU_SUB) ? (alu_a_s - alu_b_s) : (alu_a_s + alu_b_s);

  mdu_seq #(.FAST_ZERO(1'b1)) dut_f (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
    .busy(busy_f), .done(done_f), .result(result_f), .alu_a(alu_a_f), .alu_b(alu_b_f),
    .alu_ctr(alu_ctr_f), .alu_res(alu_res_f)
  );

  mdu_seq #(.FAST_ZERO(1'b0)) dut_s (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
    .busy(busy_s), .done(done_s), .result(result_s), .alu_a(alu_a_s), .alu_b(alu_b_s),
    .alu_ctr(alu_ctr_s), .alu_res(alu_res_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // RISC-V semantics straight from 64-bit arithmetic; the DIV overflow case wraps naturally.
  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0:    r = ua * ub;
      3'd1:    r = (sa * sb) >> 32;
      3'd2:    r = (sa * ub) >> 32;
      3'd3:    r = (ua * ub) >> 32;
      3'd4:    r = (b == 32'd0) ? -64'sd1 : sa / sb;
      3'd5:    r = (b == 32'd0) ? -64'sd1 : ua / ub;
      3'd6:    r = (b == 32'd0) ? sa : sa % sb;
      default: r = (b == 32'd0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy_f"}, 32'(busy_f), 32'd0);
    check_eq({tag, "_done_f"}, 32'(done_f), 32'd0);
    check_eq({tag, "_res_f"}, result_f, 32'd0);
    check_eq({tag, "_res_s"}, result_s, 32'd0);
    check_eq({tag, "_busy_s"}, 32'(busy_s), 32'd0);
    check_eq({tag, "_alua_s"}, alu_a_s, 32'd0);
    check_eq({tag, "_alub_s"}, alu_b_s, 32'd0);
    check_eq({tag, "_ctr_s"}, 32'(alu_ctr_s), 32'(ALU_ADD));
  endtask

  // Called at a falling edge; returns at a falling edge with both instances idle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    logic [31:0] exp;
    bit          zero;
    int          lat_f, lat_s, n_f, n_s;
    exp   = ref_mdu(o, a, b);
    zero  = o[2] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0));
    lat_f = 0; lat_s = 0; n_f = 0; n_s = 0;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rs1 = $urandom; rs2 = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) begin
        check_eq("busy_c1_f", 32'(busy_f), 32'd1);
        check_eq("busy_c1_s", 32'(busy_s), 32'd1);
        check_eq("prep_alua", alu_a_s, 32'd0);
      end
      if (k == 2) check_eq("run_ctr", 32'(alu_ctr_s), o[2] ? 32'(ALU_SUB) : 32'(ALU_ADD));
      if (done_f) begin n_f++; if (lat_f == 0) lat_f = k; end
      if (done_s) begin n_s++; if (lat_s == 0) lat_s = k; end
      if (poke && k == 5) begin start = 1'b1; op = ~o; rs1 = $urandom; rs2 = $urandom; end
      if (poke && k == 6) start = 1'b0;
    end
    check_eq("lat_f", 32'(lat_f), zero ? 32'd3 : 32'd35);
    check_eq("lat_s", 32'(lat_s), 32'd35);
    check_eq("ndone_f", 32'(n_f), 32'd1);
    check_eq("ndone_s", 32'(n_s), 32'd1);
    check_eq($sformatf("res_f op%0d %h %h", o, a, b), result_f, exp);
    check_eq($sformatf("res_s op%0d %h %h", o, a, b), result_s, exp);
    check_eq("idle_end", 32'(busy_f | busy_s), 32'd0);
    last_res = exp;
  endtask

  // Flush raised in cycle 10; returns at the falling edge of cycle 11.
  task automatic run_flush(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int seen;
    seen = 0;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      if (done_f || done_s) seen++;
      if (k == 10) flush = 1'b1;
      if (k == 11) begin
        flush = 1'b0;
        check_eq("flush_busy_f", 32'(busy_f), 32'd0);
        check_eq("flush_busy_s", 32'(busy_s), 32'd0);
      end
    end
    check_eq("flush_nodone", 32'(seen), 32'd0);
    check_eq("flush_res_f", result_f, last_res);
    check_eq("flush_res_s", result_s, last_res);
  endtask

  task automatic run_mid_reset(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    last_res = 32'd0;
  endtask

  logic [2:0]  d_op [16] = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd1};
  logic [31:0] d_a  [16] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                             32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1,
                             32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd0, 32'h1234_5678};
  logic [31:0] d_b  [16] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2,
                             32'd2, 32'd2, 32'd2, 32'd2,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                             32'd0, 32'd0, 32'hDEAD_BEEF, 32'd0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    for (int i = 0; i < 16; i++) run_op(d_op[i], d_a[i], d_b[i], 1'b0);

    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    run_flush(3'd4, 32'h7654_3210, 32'd3);
    run_op(3'd7, 32'hCAFE_F00D, 32'd1234, 1'b0);
    run_mid_reset(3'd2, 32'hDEAD_BEEF, 32'h0000_1234);
    run_op(3'd6, 32'h8765_4321, 32'hFFFF_FFF0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
